// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - aluop codes, RV32IM encoding constants and latency helper
package alu_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_XOR    = 5'd3;
  localparam logic [4:0] ALU_SRL    = 5'd4;
  localparam logic [4:0] ALU_SRA    = 5'd5;
  localparam logic [4:0] ALU_OR     = 5'd6;
  localparam logic [4:0] ALU_AND    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;
  localparam logic [4:0] ALU_MULH   = 5'd16;
  localparam logic [4:0] ALU_MULHSU = 5'd17;
  localparam logic [4:0] ALU_MULHU  = 5'd18;
  localparam logic [4:0] ALU_MUL    = 5'd22;
  localparam logic [4:0] ALU_DIV    = 5'd24;
  localparam logic [4:0] ALU_DIVU   = 5'd26;
  localparam logic [4:0] ALU_REM    = 5'd28;
  localparam logic [4:0] ALU_REMU   = 5'd30;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;
  localparam logic [6:0] F7_MULDIV  = 7'h01;

  // Cycles spent in EXEC: the op's ALU latency plus one to capture the registered ALU output.
  function automatic logic [7:0] op_hold(input logic is_m, input logic [4:0] op,
                                         input int base, input int mul, input int div);
    logic [7:0] r_n;
    r_n = 8'(base + 1);
    if (is_m) begin
      if (op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU)
        r_n = 8'(div + 1);
      else
        r_n = 8'(mul + 1);
    end
    return r_n;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational instruction to aluop/operand mapping
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [4:0]  aluop,
  output logic [31:0] aluin1,
  output logic [31:0] aluin2,
  output logic        is_m,
  output logic        illegal
);

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_unused;

  assign w_f3     = inst[14:12];
  assign w_f7     = inst[31:25];
  assign w_imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_u  = {inst[31:12], 12'b0};
  assign w_unused = ^{inst[19:15], inst[11:7]};

  always_comb begin
    aluop   = ALU_ADD;
    aluin1  = rs1;
    aluin2  = rs2;
    is_m    = 1'b0;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            3'd0: aluop = ALU_ADD;
            3'd1: aluop = ALU_SLL;
            3'd2: aluop = ALU_SLT;
            3'd3: aluop = ALU_SLTU;
            3'd4: aluop = ALU_XOR;
            3'd5: aluop = ALU_SRL;
            3'd6: aluop = ALU_OR;
            default: aluop = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'd0)      aluop = ALU_SUB;
          else if (w_f3 == 3'd5) aluop = ALU_SRA;
          else                   illegal = 1'b1;
        end else if (w_f7 == F7_MULDIV) begin
          is_m = 1'b1;
          case (w_f3)
            3'd0: aluop = ALU_MUL;
            3'd1: aluop = ALU_MULH;
            3'd2: aluop = ALU_MULHSU;
            3'd3: aluop = ALU_MULHU;
            3'd4: aluop = ALU_DIV;
            3'd5: aluop = ALU_DIVU;
            3'd6: aluop = ALU_REM;
            default: aluop = ALU_REMU;
          endcase
        end else begin
          illegal = 1'b1;
        end
        if (!is_m && (w_f3 == 3'd1 || w_f3 == 3'd5))
          aluin2 = {27'b0, rs2[4:0]};
      end
      OPC_OPIMM: begin
        aluin2 = w_imm_i;
        case (w_f3)
          3'd0: aluop = ALU_ADD;
          3'd1: begin
            aluop  = ALU_SLL;
            aluin2 = {27'b0, inst[24:20]};
            if (w_f7 != F7_BASE) illegal = 1'b1;
          end
          3'd2: aluop = ALU_SLT;
          3'd3: aluop = ALU_SLTU;
          3'd4: aluop = ALU_XOR;
          3'd5: begin
            aluin2 = {27'b0, inst[24:20]};
            if (w_f7 == F7_BASE)     aluop = ALU_SRL;
            else if (w_f7 == F7_ALT) aluop = ALU_SRA;
            else                     illegal = 1'b1;
          end
          3'd6: aluop = ALU_OR;
          default: aluop = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        aluin1 = 32'b0;
        aluin2 = w_imm_u;
      end
      OPC_AUIPC: begin
        aluin1 = pc;
        aluin2 = w_imm_u;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-stage issue FSM holding ALU operands and returning fixed-up results
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BASE_CYCLES = 1,
  parameter int MUL_CYCLES  = 2,
  parameter int DIV_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic [4:0]      aluop,
  output logic [XLEN-1:0] aluin1,
  output logic [XLEN-1:0] aluin2,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]      r_state;
  logic [7:0]      r_cnt;
  logic [4:0]      r_aluop;
  logic [XLEN-1:0] r_aluin1;
  logic [XLEN-1:0] r_aluin2;
  logic [XLEN-1:0] r_wb_data;
  logic [4:0]      r_wb_rd;
  logic            r_wb_illegal;

  logic [4:0]      w_aluop;
  logic [XLEN-1:0] w_aluin1;
  logic [XLEN-1:0] w_aluin2;
  logic            w_is_m;
  logic            w_illegal;
  logic [XLEN-1:0] w_fixed;
  logic            w_div0;
  logic            w_ovf;

  alu_decode u_decode (
    .inst    (in_inst),
    .pc      (in_pc),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .aluop   (w_aluop),
    .aluin1  (w_aluin1),
    .aluin2  (w_aluin2),
    .is_m    (w_is_m),
    .illegal (w_illegal)
  );

  // RISC-V defines div/rem results for divide-by-zero and signed overflow; the ALU does not.
  assign w_div0 = (r_aluin2 == '0);
  assign w_ovf  = (r_aluin1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_aluin2 == '1);

  always_comb begin
    w_fixed = alu_result;
    case (r_aluop)
      ALU_DIV:  if (w_div0) w_fixed = '1;
                else if (w_ovf) w_fixed = {1'b1, {(XLEN-1){1'b0}}};
      ALU_DIVU: if (w_div0) w_fixed = '1;
      ALU_REM:  if (w_div0) w_fixed = r_aluin1;
                else if (w_ovf) w_fixed = '0;
      ALU_REMU: if (w_div0) w_fixed = r_aluin1;
      default:  w_fixed = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_aluop      <= '0;
      r_aluin1     <= '0;
      r_aluin2     <= '0;
      r_wb_data    <= '0;
      r_wb_rd      <= '0;
      r_wb_illegal <= 1'b0;
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_wb_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_wb_rd <= in_inst[11:7];
            if (w_illegal) begin
              r_state      <= S_WB;
              r_wb_illegal <= 1'b1;
              r_wb_data    <= '0;
            end else begin
              r_state  <= S_EXEC;
              r_aluop  <= w_aluop;
              r_aluin1 <= w_aluin1;
              r_aluin2 <= w_aluin2;
              r_cnt    <= op_hold(w_is_m, w_aluop, BASE_CYCLES, MUL_CYCLES, DIV_CYCLES);
            end
          end
        end
        S_EXEC: begin
          if (r_cnt == 8'd1) begin
            r_state   <= S_WB;
            r_wb_data <= w_fixed;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            r_state      <= S_IDLE;
            r_wb_illegal <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign wb_valid   = (r_state == S_WB);
  assign aluop      = r_aluop;
  assign aluin1     = r_aluin1;
  assign aluin2     = r_aluin2;
  assign wb_data    = r_wb_data;
  assign wb_rd      = r_wb_rd;
  assign wb_illegal = r_wb_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a behavioural registered ALU
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc, in_rs1, in_rs2;
  logic        flush;
  logic [4:0]  aluop;
  logic [31:0] aluin1, aluin2;
  logic [31:0] alu_result = 32'b0;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_illegal;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .flush(flush), .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_illegal(wb_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Undefined div/rem cases return a marker so only the issue block's fixup can make them right.
  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        bad;
    bad = (b == 32'h0) || (a == 32'h80000000 && b == 32'hFFFFFFFF);
    p = 64'($signed(a)) * 64'($signed(b));
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << b;
      5'd3:  r = a ^ b;
      5'd4:  r = a >> b;
      5'd5:  r = $signed(a) >>> b;
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd8:  r = {31'b0, $signed(a) < $signed(b)};
      5'd9:  r = {31'b0, a < b};
      5'd16: r = p[63:32];
      5'd22: r = p[31:0];
      5'd24: r = bad ? 32'h0BADF00D : 32'($signed(a) / $signed(b));
      5'd26: r = (b == 0) ? 32'h0BADF00D : a / b;
      5'd28: r = bad ? 32'h0BADF00D : 32'($signed(a) % $signed(b));
      5'd30: r = (b == 0) ? 32'h0BADF00D : a % b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_result <= alu_f(aluop, aluin1, aluin2);

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ill;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, r2, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Monitor: timing, stability while stalled, and in-order comparison at each handshake.
  logic        prev_v = 1'b0;
  int          rise_cyc = 0;
  logic [31:0] held = 32'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      prev_v = 1'b0;
    end else if (wb_valid) begin
      if (!prev_v) begin
        rise_cyc = cyc;
        held = wb_data;
      end else begin
        chk("wb_data_stable", wb_data, held);
      end
      chk("in_ready_in_wb", {31'b0, in_ready}, 32'd0);
      prev_v = 1'b1;
      if (wb_ready) begin
        prev_v = 1'b0;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_wb: got wb_data %h rd %0d, required no writeback", wb_data, wb_rd);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_illegal", {31'b0, wb_illegal}, {31'b0, e.ill});
          chk("wb_latency", 32'(rise_cyc), 32'(e.cyc));
        end
      end
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input bit push, input logic [31:0] data,
                       input bit ill, input int offs, input bit chk_ops, input logic [4:0] op,
                       input logic [31:0] in1, input logic [31:0] in2);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready 0, required 1 within 50 cycles");
    end
    in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) begin
      e.data = data; e.rd = inst[11:7]; e.ill = ill; e.cyc = cyc + offs;
      sb.push_back(e);
    end
    if (chk_ops) begin
      chk("aluop", {27'b0, aluop}, {27'b0, op});
      chk("aluin1", aluin1, in1);
      chk("aluin2", aluin2, in2);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || wb_valid) && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
    chk({tag, "_wb_illegal"}, {31'b0, wb_illegal}, 32'd0);
    chk({tag, "_aluop"}, {27'b0, aluop}, 32'd0);
    chk({tag, "_aluin1"}, aluin1, 32'd0);
    chk({tag, "_aluin2"}, aluin2, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_rd"}, {27'b0, wb_rd}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    in_inst = 32'b0; in_pc = 32'b0; in_rs1 = 32'b0; in_rs2 = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // addi x5, x1, -3
    issue({12'hFFD, 5'd1, 3'd0, 5'd5, 7'h13}, 32'h0, 32'd7, 32'h0, 1, 32'd4, 0, 2,
          1, 5'd0, 32'd7, 32'hFFFFFFFD);
    drain();
    // srai x6, x1, 4
    issue({7'h20, 5'd4, 5'd1, 3'd5, 5'd6, 7'h13}, 32'h0, 32'h80000000, 32'h0, 1, 32'hF8000000, 0, 2,
          1, 5'd5, 32'h80000000, 32'd4);
    drain();
    // sll x7: only rs2[4:0] reaches the ALU
    issue(enc_r(7'h00, 5'd2, 3'd1, 5'd7, 7'h33), 32'h0, 32'h12345678, 32'h21, 1, 32'h2468ACF0, 0, 2,
          1, 5'd2, 32'h12345678, 32'd1);
    drain();
    issue(enc_r(7'h20, 5'd2, 3'd0, 5'd13, 7'h33), 32'h0, 32'd10, 32'd3, 1, 32'd7, 0, 2,
          1, 5'd1, 32'd10, 32'd3);
    drain();
    issue(enc_u(20'h12345, 5'd11, 7'h37), 32'h0, 32'hAAAAAAAA, 32'h0, 1, 32'h12345000, 0, 2,
          1, 5'd0, 32'h0, 32'h12345000);
    drain();
    issue(enc_u(20'h00001, 5'd12, 7'h17), 32'h1000, 32'hAAAAAAAA, 32'h0, 1, 32'h2000, 0, 2,
          1, 5'd0, 32'h1000, 32'h1000);
    drain();

    // div/rem corner cases
    issue(enc_r(7'h01, 5'd2, 3'd4, 5'd8, 7'h33), 32'h0, 32'hFFFFFFF9, 32'h0, 1, 32'hFFFFFFFF, 0, 5,
          1, 5'd24, 32'hFFFFFFF9, 32'h0);
    drain();
    issue(enc_r(7'h01, 5'd2, 3'd6, 5'd9, 7'h33), 32'h0, 32'hFFFFFFF9, 32'h0, 1, 32'hFFFFFFF9, 0, 5,
          1, 5'd28, 32'hFFFFFFF9, 32'h0);
    drain();
    issue(enc_r(7'h01, 5'd2, 3'd4, 5'd14, 7'h33), 32'h0, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, 5,
          1, 5'd24, 32'h80000000, 32'hFFFFFFFF);
    drain();
    issue(enc_r(7'h01, 5'd2, 3'd6, 5'd15, 7'h33), 32'h0, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 0, 5,
          1, 5'd28, 32'h80000000, 32'hFFFFFFFF);
    drain();
    issue(enc_r(7'h01, 5'd2, 3'd5, 5'd16, 7'h33), 32'h0, 32'd100, 32'd7, 1, 32'd14, 0, 5,
          1, 5'd26, 32'd100, 32'd7);
    drain();

    // mul with writeback stalled for 5 cycles
    wb_ready = 1'b0;
    issue(enc_r(7'h01, 5'd2, 3'd0, 5'd10, 7'h33), 32'h0, 32'd3, 32'hFFFFFFFE, 1, 32'hFFFFFFFA, 0, 3,
          1, 5'd22, 32'd3, 32'hFFFFFFFE);
    repeat (8) @(posedge clk);
    #1;
    wb_ready = 1'b1;
    drain();

    // flush during divu EXEC, then a normal addi
    issue(enc_r(7'h01, 5'd2, 3'd5, 5'd17, 7'h33), 32'h0, 32'd50, 32'd5, 0, 32'h0, 0, 0,
          1, 5'd26, 32'd50, 32'd5);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_wb_valid", {31'b0, wb_valid}, 32'd0);
    repeat (8) @(posedge clk);
    // flush and in_valid together in IDLE: no accept
    #1;
    in_inst = {12'h001, 5'd1, 3'd0, 5'd18, 7'h13}; in_rs1 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_beats_valid", {31'b0, in_ready}, 32'd1);
    repeat (4) @(posedge clk);
    issue({12'h005, 5'd1, 3'd0, 5'd19, 7'h13}, 32'h0, 32'd20, 32'h0, 1, 32'd25, 0, 2,
          1, 5'd0, 32'd20, 32'd5);
    drain();

    // illegal encodings: branch, and OP with f7=0x20 f3=1
    issue(32'h00208463, 32'h0, 32'd1, 32'd2, 1, 32'h0, 1, 0, 0, 5'd0, 32'h0, 32'h0);
    drain();
    issue(enc_r(7'h20, 5'd2, 3'd1, 5'd20, 7'h33), 32'h0, 32'd1, 32'd2, 1, 32'h0, 1, 0, 0, 5'd0, 32'h0, 32'h0);
    drain();

    // reset mid-EXEC drops the op
    issue(enc_r(7'h01, 5'd2, 3'd4, 5'd21, 7'h33), 32'h0, 32'd5, 32'd1, 0, 32'h0, 0, 0,
          1, 5'd24, 32'd5, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (8) @(posedge clk);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
